// File: rtl/banco_registros_mp.sv
// Multi-port register bank: RD_PORTS combinational reads, WR_PORTS clocked writes,
// optional hardwired-zero register 0, write-to-read bypass and a busy scoreboard.
module banco_registros_mp #(
  parameter int N        = 32,
  parameter int Bits     = 64,
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int W       = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RD_PORTS*W-1:0]    ptr_rd,
  output logic [RD_PORTS*Bits-1:0] data_rd,
  output logic [RD_PORTS-1:0]      busy_rd,
  input  logic [WR_PORTS*W-1:0]    ptr_wr,
  input  logic [WR_PORTS*Bits-1:0] data_wr,
  input  logic [WR_PORTS-1:0]      wr_en,
  input  logic                     rsv_en,
  input  logic [W-1:0]             rsv_ptr,
  output logic [N-1:0]             busy_vec
);

  logic [Bits-1:0] regs_q [N];

  genvar gi;

  // One slice per register: write-port priority, scoreboard update and storage.
  generate
    for (gi = 0; gi < N; gi++) begin : g_reg
      localparam bit IS_ZERO = (ZERO_REG != 0) && (gi == 0);

      logic [Bits-1:0] data_reg;
      logic [Bits-1:0] data_next;
      logic            busy_reg;
      logic            busy_next;
      logic            wr_hit;
      logic            rsv_hit;

      always_comb begin
        wr_hit    = 1'b0;
        data_next = data_reg;
        // Ascending scan so the highest-index enabled port wins a collision.
        for (int p = 0; p < WR_PORTS; p++) begin
          if (wr_en[p] && (ptr_wr[p*W +: W] == W'(gi))) begin
            wr_hit    = 1'b1;
            data_next = data_wr[p*Bits +: Bits];
          end
        end
        rsv_hit = rsv_en && (rsv_ptr == W'(gi));
        if (IS_ZERO) begin
          wr_hit    = 1'b0;
          rsv_hit   = 1'b0;
          data_next = '0;
        end
        // A same-edge reservation means a newer producer is pending, so it beats the clear.
        busy_next = rsv_hit ? 1'b1 : (wr_hit ? 1'b0 : busy_reg);
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          data_reg <= '0;
          busy_reg <= 1'b0;
        end else begin
          data_reg <= data_next;
          busy_reg <= busy_next;
        end
      end

      assign regs_q[gi]   = data_reg;
      assign busy_vec[gi] = busy_reg;
    end
  endgenerate

  generate
    for (gi = 0; gi < RD_PORTS; gi++) begin : g_rd
      logic [W-1:0]    rd_ptr;
      logic [Bits-1:0] rd_data;

      assign rd_ptr = ptr_rd[gi*W +: W];

      always_comb begin
        rd_data = regs_q[rd_ptr];
        // Bypass is suppressed during reset so reads stay zero until release.
        if ((BYPASS != 0) && rst && !((ZERO_REG != 0) && (rd_ptr == '0))) begin
          for (int p = 0; p < WR_PORTS; p++) begin
            if (wr_en[p] && (ptr_wr[p*W +: W] == rd_ptr)) begin
              rd_data = data_wr[p*Bits +: Bits];
            end
          end
        end
      end

      assign data_rd[gi*Bits +: Bits] = rd_data;
      assign busy_rd[gi]              = busy_vec[rd_ptr];
    end
  endgenerate

endmodule

// File: tb/tb_banco_registros_mp.sv
// Directed bench for banco_registros_mp: one bypassing instance and one non-bypassing
// instance share all inputs so the two read behaviours can be compared side by side.
module tb_banco_registros_mp;

  logic         clk = 1'b0;
  logic         rst;
  logic [9:0]   ptr_rd;
  logic [127:0] data_rd;
  logic [1:0]   busy_rd;
  logic [9:0]   ptr_wr;
  logic [127:0] data_wr;
  logic [1:0]   wr_en;
  logic         rsv_en;
  logic [4:0]   rsv_ptr;
  logic [31:0]  busy_vec;

  logic [127:0] data_rd_nb;
  logic [1:0]   busy_rd_nb;
  logic [31:0]  busy_vec_nb;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  banco_registros_mp #(.N(32), .Bits(64), .RD_PORTS(2), .WR_PORTS(2), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .ptr_rd(ptr_rd), .data_rd(data_rd), .busy_rd(busy_rd),
    .ptr_wr(ptr_wr), .data_wr(data_wr), .wr_en(wr_en), .rsv_en(rsv_en),
    .rsv_ptr(rsv_ptr), .busy_vec(busy_vec)
  );

  banco_registros_mp #(.N(32), .Bits(64), .RD_PORTS(2), .WR_PORTS(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .ptr_rd(ptr_rd), .data_rd(data_rd_nb), .busy_rd(busy_rd_nb),
    .ptr_wr(ptr_wr), .data_wr(data_wr), .wr_en(wr_en), .rsv_en(rsv_en),
    .rsv_ptr(rsv_ptr), .busy_vec(busy_vec_nb)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 2'b00;
    rsv_en = 1'b0;
  endtask

  task automatic set_rd(input logic [4:0] p0, input logic [4:0] p1);
    ptr_rd = {p1, p0};
  endtask

  task automatic set_wr(input int p, input logic [4:0] ptr, input logic [63:0] d);
    ptr_wr[p*5 +: 5]   = ptr;
    data_wr[p*64 +: 64] = d;
    wr_en[p]           = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; ptr_rd = '0; ptr_wr = '0; data_wr = '0; wr_en = '0; rsv_en = 1'b0; rsv_ptr = '0;
    #3;
    total_cnt++;
    if (data_rd !== 128'd0) $display("FAIL reset_data_rd got=%h exp=0", data_rd);
    else pass_cnt++;
    total_cnt++;
    if (busy_vec !== 32'd0) $display("FAIL reset_busy_vec got=%h exp=0", busy_vec);
    else pass_cnt++;
    step();
    step();
    rst = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_dual_write();
    set_wr(0, 5'd1, 64'd10); set_wr(1, 5'd2, 64'd20);
    step();
    set_wr(0, 5'd3, 64'd30); set_wr(1, 5'd4, 64'd40);
    step();
    idle();
    set_rd(5'd3, 5'd4);
    #1;
    total_cnt++;
    if (data_rd[63:0] !== 64'd30 || data_rd[127:64] !== 64'd40)
      $display("FAIL dual_write_34 got=%0d,%0d exp=30,40", data_rd[63:0], data_rd[127:64]);
    else pass_cnt++;
    set_rd(5'd1, 5'd2);
    #1;
    total_cnt++;
    if (data_rd[63:0] !== 64'd10 || data_rd[127:64] !== 64'd20)
      $display("FAIL dual_write_12 got=%0d,%0d exp=10,20", data_rd[63:0], data_rd[127:64]);
    else pass_cnt++;
    $display("dual_write: regs 1..4 filled");
  endtask

  task automatic test_collision();
    set_rd(5'd5, 5'd1);
    set_wr(0, 5'd5, 64'd50); set_wr(1, 5'd5, 64'd55);
    #1;
    total_cnt++;
    if (data_rd[63:0] !== 64'd55) $display("FAIL collision_bypass got=%0d exp=55", data_rd[63:0]);
    else pass_cnt++;
    total_cnt++;
    if (data_rd_nb[63:0] !== 64'd0) $display("FAIL collision_nobypass got=%0d exp=0", data_rd_nb[63:0]);
    else pass_cnt++;
    step();
    idle();
    #1;
    total_cnt++;
    if (data_rd_nb[63:0] !== 64'd55) $display("FAIL collision_stored got=%0d exp=55", data_rd_nb[63:0]);
    else pass_cnt++;
    $display("collision: reg5 written by both ports");
  endtask

  task automatic test_wr_disable();
    idle();
    for (int i = 1; i <= 4; i++) begin
      ptr_wr  = {5'(i), 5'(i)};
      data_wr = {64'(i), 64'(i)};
      step();
    end
    set_rd(5'd1, 5'd2);
    #1;
    total_cnt++;
    if (data_rd !== {64'd20, 64'd10}) $display("FAIL wr_disable_12 got=%h exp=20,10", data_rd);
    else pass_cnt++;
    set_rd(5'd3, 5'd4);
    #1;
    total_cnt++;
    if (data_rd !== {64'd40, 64'd30}) $display("FAIL wr_disable_34 got=%h exp=40,30", data_rd);
    else pass_cnt++;
    $display("wr_disable: regs 1..4 unchanged");
  endtask

  task automatic test_zero_reg();
    set_rd(5'd0, 5'd0);
    set_wr(0, 5'd0, 64'hFFFF);
    rsv_en = 1'b1; rsv_ptr = 5'd0;
    #1;
    total_cnt++;
    if (data_rd !== 128'd0) $display("FAIL zero_no_bypass got=%h exp=0", data_rd);
    else pass_cnt++;
    step();
    idle();
    #1;
    total_cnt++;
    if (data_rd !== 128'd0) $display("FAIL zero_stored got=%h exp=0", data_rd);
    else pass_cnt++;
    total_cnt++;
    if (busy_vec !== 32'd0 || busy_rd !== 2'b00)
      $display("FAIL zero_busy got vec=%h rd=%b exp=0", busy_vec, busy_rd);
    else pass_cnt++;
    $display("zero_reg: write and reserve dropped");
  endtask

  task automatic test_bypass();
    set_rd(5'd1, 5'd6);
    set_wr(0, 5'd6, 64'd60);
    #1;
    total_cnt++;
    if (data_rd[127:64] !== 64'd60) $display("FAIL bypass_on got=%0d exp=60", data_rd[127:64]);
    else pass_cnt++;
    total_cnt++;
    if (data_rd_nb[127:64] !== 64'd0) $display("FAIL bypass_off got=%0d exp=0", data_rd_nb[127:64]);
    else pass_cnt++;
    step();
    idle();
    #1;
    total_cnt++;
    if (data_rd_nb[127:64] !== 64'd60) $display("FAIL bypass_after got=%0d exp=60", data_rd_nb[127:64]);
    else pass_cnt++;
    $display("bypass: reg6 = 60");
  endtask

  task automatic test_scoreboard();
    rsv_en = 1'b1; rsv_ptr = 5'd7;
    step();
    idle();
    set_rd(5'd7, 5'd6);
    #1;
    total_cnt++;
    if (busy_vec !== 32'h0000_0080 || busy_rd !== 2'b01)
      $display("FAIL sb_reserve got vec=%h rd=%b exp=00000080,01", busy_vec, busy_rd);
    else pass_cnt++;
    // Write to busy reg 7 and to non-busy reg 8; busy_rd must not see the pending clear.
    set_wr(0, 5'd7, 64'd70); set_wr(1, 5'd8, 64'd80);
    #1;
    total_cnt++;
    if (busy_rd[0] !== 1'b1) $display("FAIL sb_no_clear_bypass got=%b exp=1", busy_rd[0]);
    else pass_cnt++;
    step();
    idle();
    #1;
    total_cnt++;
    if (busy_vec !== 32'd0 || data_rd[63:0] !== 64'd70)
      $display("FAIL sb_release got vec=%h d=%0d exp=0,70", busy_vec, data_rd[63:0]);
    else pass_cnt++;
    rsv_en = 1'b1; rsv_ptr = 5'd7;
    set_wr(1, 5'd7, 64'd71);
    step();
    idle();
    #1;
    total_cnt++;
    if (busy_vec !== 32'h0000_0080 || data_rd[63:0] !== 64'd71)
      $display("FAIL sb_rsv_wins got vec=%h d=%0d exp=00000080,71", busy_vec, data_rd[63:0]);
    else pass_cnt++;
    rsv_en = 1'b1; rsv_ptr = 5'd7;
    step();
    idle();
    #1;
    total_cnt++;
    if (busy_vec !== 32'h0000_0080) $display("FAIL sb_rereserve got=%h exp=00000080", busy_vec);
    else pass_cnt++;
    $display("scoreboard: reg7 busy, value 71");
  endtask

  task automatic test_back_to_back();
    set_wr(0, 5'd9, 64'd90);
    step();
    set_wr(0, 5'd10, 64'd100);
    set_rd(5'd9, 5'd10);
    #1;
    total_cnt++;
    if (data_rd !== {64'd100, 64'd90}) $display("FAIL b2b_bypass got=%h exp=100,90", data_rd);
    else pass_cnt++;
    total_cnt++;
    if (data_rd_nb !== {64'd0, 64'd90}) $display("FAIL b2b_nobypass got=%h exp=0,90", data_rd_nb);
    else pass_cnt++;
    step();
    idle();
    $display("back_to_back: regs 9,10 written");
  endtask

  task automatic test_async_reset();
    set_rd(5'd7, 5'd1);
    #2;
    rst = 1'b0;
    set_wr(0, 5'd1, 64'd10);
    #1;
    total_cnt++;
    if (data_rd !== 128'd0 || data_rd_nb !== 128'd0)
      $display("FAIL async_reset_data got=%h,%h exp=0", data_rd, data_rd_nb);
    else pass_cnt++;
    total_cnt++;
    if (busy_vec !== 32'd0 || busy_rd !== 2'b00)
      $display("FAIL async_reset_busy got vec=%h rd=%b exp=0", busy_vec, busy_rd);
    else pass_cnt++;
    step();
    @(negedge clk);
    rst = 1'b1;
    step();
    idle();
    #1;
    total_cnt++;
    if (data_rd_nb[127:64] !== 64'd10 || data_rd_nb[63:0] !== 64'd0)
      $display("FAIL async_release got=%0d,%0d exp=10,0", data_rd_nb[127:64], data_rd_nb[63:0]);
    else pass_cnt++;
    $display("async_reset: cleared, reg1 = 10 after release");
  endtask

  initial begin
    test_reset();
    test_dual_write();
    test_collision();
    test_wr_disable();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
